fme_rd_sched: RTL and testbench

Read scheduler for the FME reference loader. Per macroblock, it walks the partition and sub-partition layout and issues one read command per block: start pulse, row count and block count. Commands can be issued back-to-back so the loader stays in its run state between blocks. It sits between the FME top-level control and the loader, and tags each command with partition/sub-partition indices for the interpolator.

---
 rtl/fme_rd_sched.sv | 166 ++++++++++++++++
 tb/tb_fme_rd_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fme_rd_sched.sv
// Read-command scheduler for the FME reference loader: walks the partition /
// sub-partition layout of one macroblock and issues one loader command per block.
module fme_rd_sched (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [1:0] mb_type_i,
    input  logic [7:0] sub_type_i,
    input  logic       hold_i,
    input  logic       end_rd_i,
    output logic       start_rd_o,
    output logic [4:0] rd_row_o,
    output logic [1:0] rd_blk_o,
    output logic [1:0] part_idx_o,
    output logic [1:0] sub_idx_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MB_16X16 = 2'd0;
    localparam logic [1:0] MB_16X8  = 2'd1;
    localparam logic [1:0] MB_8X16  = 2'd2;
    localparam logic [1:0] MB_8X8   = 2'd3;

    state_t     state_q;
    logic [1:0] mb_type_q;
    logic [7:0] sub_type_q;
    logic [1:0] part_ptr_q, part_ptr_d;
    logic [1:0] sub_ptr_q, sub_ptr_d;
    logic       last_q;
    logic [1:0] part_idx_q;
    logic [1:0] sub_idx_q;

    logic [1:0] cur_sub_type;
    logic [1:0] part_max;
    logic [1:0] sub_max;
    logic       sub_wrap;
    logic       cmd_is_last;
    logic       start_rd;

    // Sub-MB shape of the partition the pointer currently addresses.
    assign cur_sub_type = sub_type_q[{part_ptr_q, 1'b0} +: 2];

    always_comb begin
        part_max = 2'd0;
        sub_max  = 2'd0;
        rd_row_o = 5'd21;
        rd_blk_o = 2'd1;
        case (mb_type_q)
            MB_16X16: begin
                part_max = 2'd0;
                rd_row_o = 5'd21;
                rd_blk_o = 2'd1;
            end
            MB_16X8: begin
                part_max = 2'd1;
                rd_row_o = 5'd13;
                rd_blk_o = 2'd1;
            end
            MB_8X16: begin
                part_max = 2'd1;
                rd_row_o = 5'd21;
                rd_blk_o = 2'd0;
            end
            default: begin
                part_max = 2'd3;
                rd_blk_o = 2'd0;
                case (cur_sub_type)
                    2'd0: begin sub_max = 2'd0; rd_row_o = 5'd13; end
                    2'd1: begin sub_max = 2'd1; rd_row_o = 5'd9;  end
                    2'd2: begin sub_max = 2'd1; rd_row_o = 5'd13; end
                    default: begin sub_max = 2'd3; rd_row_o = 5'd9; end
                endcase
            end
        endcase
    end

    assign sub_wrap    = (sub_ptr_q == sub_max);
    assign cmd_is_last = sub_wrap && (part_ptr_q == part_max);

    always_comb begin
        part_ptr_d = part_ptr_q;
        sub_ptr_d  = sub_ptr_q;
        if (sub_wrap) begin
            sub_ptr_d  = 2'd0;
            part_ptr_d = part_ptr_q + 2'd1;
        end else begin
            sub_ptr_d = sub_ptr_q + 2'd1;
        end
    end

    // Chained issue in WAIT lets the loader go straight into the next block.
    always_comb begin
        start_rd = 1'b0;
        case (state_q)
            ST_ISSUE: start_rd = !hold_i;
            ST_WAIT:  start_rd = end_rd_i && !last_q && !hold_i;
            default:  start_rd = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            mb_type_q  <= 2'd0;
            sub_type_q <= 8'd0;
            part_ptr_q <= 2'd0;
            sub_ptr_q  <= 2'd0;
            last_q     <= 1'b0;
            part_idx_q <= 2'd0;
            sub_idx_q  <= 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q    <= ST_ISSUE;
                        mb_type_q  <= mb_type_i;
                        sub_type_q <= sub_type_i;
                        part_ptr_q <= 2'd0;
                        sub_ptr_q  <= 2'd0;
                        last_q     <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (start_rd) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (end_rd_i) begin
                        if (last_q) begin
                            state_q <= ST_DONE;
                        end else if (hold_i) begin
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            if (start_rd) begin
                part_idx_q <= part_ptr_q;
                sub_idx_q  <= sub_ptr_q;
                last_q     <= cmd_is_last;
                part_ptr_q <= part_ptr_d;
                sub_ptr_q  <= sub_ptr_d;
            end
        end
    end

    assign start_rd_o = start_rd;
    assign part_idx_o = part_idx_q;
    assign sub_idx_o  = sub_idx_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_DONE);

endmodule

// File: tb/tb_fme_rd_sched.sv
// Directed bench for fme_rd_sched: command sequences per macroblock type,
// hold behaviour, ignored inputs and mid-MB reset.
module tb_fme_rd_sched;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic [1:0] mb_type_i;
    logic [7:0] sub_type_i;
    logic       hold_i;
    logic       end_rd_i;
    logic       start_rd_o;
    logic [4:0] rd_row_o;
    logic [1:0] rd_blk_o;
    logic [1:0] part_idx_o;
    logic [1:0] sub_idx_o;
    logic       busy_o;
    logic       done_o;

    int total = 0;
    int bad   = 0;

    fme_rd_sched dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .mb_type_i  (mb_type_i),
        .sub_type_i (sub_type_i),
        .hold_i     (hold_i),
        .end_rd_i   (end_rd_i),
        .start_rd_o (start_rd_o),
        .rd_row_o   (rd_row_o),
        .rd_blk_o   (rd_blk_o),
        .part_idx_o (part_idx_o),
        .sub_idx_o  (sub_idx_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Current cycle must carry a strobe with (row, blk); the following cycle
    // must show the indices of that command and no strobe.
    task automatic issue_chk(input string tag, input int row, input int blk,
                             input int p, input int s);
        #1;
        chk({tag, ".strobe"}, 32'(start_rd_o), 32'd1);
        chk({tag, ".row"}, 32'(rd_row_o), 32'(row));
        chk({tag, ".blk"}, 32'(rd_blk_o), 32'(blk));
        tick();
        end_rd_i = 1'b0;
        #1;
        chk({tag, ".part"}, 32'(part_idx_o), 32'(p));
        chk({tag, ".sub"}, 32'(sub_idx_o), 32'(s));
        chk({tag, ".nostrobe"}, 32'(start_rd_o), 32'd0);
        $display("cmd %s row=%0d blk=%0d part=%0d sub=%0d", tag, rd_row_o, rd_blk_o,
                 part_idx_o, sub_idx_o);
    endtask

    // Final end_rd_i: no strobe, then done_o pulse, then idle.
    task automatic finish_chk(input string tag);
        end_rd_i = 1'b1;
        #1;
        chk({tag, ".last_nostrobe"}, 32'(start_rd_o), 32'd0);
        tick();
        end_rd_i = 1'b0;
        #1;
        chk({tag, ".done"}, 32'(done_o), 32'd1);
        chk({tag, ".busy_done"}, 32'(busy_o), 32'd1);
        tick();
        #1;
        chk({tag, ".done_clr"}, 32'(done_o), 32'd0);
        chk({tag, ".idle"}, 32'(busy_o), 32'd0);
        $display("mb %s complete", tag);
    endtask

    task automatic start_mb(input logic [1:0] t, input logic [7:0] st);
        mb_type_i  = t;
        sub_type_i = st;
        start_i    = 1'b1;
        tick();
        start_i    = 1'b0;
        mb_type_i  = 2'd0;
        sub_type_i = 8'd0;
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, ".start_rd"}, 32'(start_rd_o), 32'd0);
        chk({tag, ".done"}, 32'(done_o), 32'd0);
        chk({tag, ".busy"}, 32'(busy_o), 32'd0);
        chk({tag, ".part"}, 32'(part_idx_o), 32'd0);
        chk({tag, ".sub"}, 32'(sub_idx_o), 32'd0);
        chk({tag, ".row"}, 32'(rd_row_o), 32'd21);
        chk({tag, ".blk"}, 32'(rd_blk_o), 32'd1);
        $display("reset %s checked", tag);
    endtask

    int rows9[9] = '{13, 9, 9, 13, 13, 9, 9, 9, 9};
    int pidx9[9] = '{0, 1, 1, 2, 2, 3, 3, 3, 3};
    int sidx9[9] = '{0, 0, 1, 0, 1, 0, 1, 2, 3};

    initial begin
        rst_i = 1'b1; start_i = 1'b0; mb_type_i = 2'd0; sub_type_i = 8'd0;
        hold_i = 1'b0; end_rd_i = 1'b0;
        tick(); tick();
        reset_chk("rst0");
        rst_i = 1'b0;
        tick();

        // 16x16: single command, start_i during DONE is ignored
        start_mb(2'd0, 8'd0);
        issue_chk("t0", 21, 1, 0, 0);
        chk("t0.busy", 32'(busy_o), 32'd1);
        tick(); tick();
        end_rd_i = 1'b1;
        #1;
        chk("t0.last_nostrobe", 32'(start_rd_o), 32'd0);
        tick();
        end_rd_i = 1'b0;
        start_i  = 1'b1;
        #1;
        chk("t0.done", 32'(done_o), 32'd1);
        tick();
        start_i = 1'b0;
        #1;
        chk("t0.start_in_done_ignored", 32'(busy_o), 32'd0);
        tick();
        #1;
        chk("t0.still_idle", 32'(busy_o), 32'd0);

        // 16x8: second strobe chained onto the first end_rd_i
        start_mb(2'd1, 8'd0);
        issue_chk("t1a", 13, 1, 0, 0);
        tick();
        end_rd_i = 1'b1;
        issue_chk("t1b", 13, 1, 1, 0);
        tick();
        finish_chk("t1");

        // 8x8 with sub-types 8x8, 8x4, 4x8, 4x4: nine chained commands
        start_mb(2'd3, 8'b11_10_01_00);
        for (int i = 0; i < 9; i++) begin
            if (i != 0) end_rd_i = 1'b1;
            issue_chk($sformatf("t3.%0d", i), rows9[i], 0, pidx9[i], sidx9[i]);
        end
        finish_chk("t3");

        // 8x16 with hold across the second end_rd_i
        start_mb(2'd2, 8'd0);
        issue_chk("t2a", 21, 0, 0, 0);
        hold_i   = 1'b1;
        end_rd_i = 1'b1;
        #1;
        chk("t2.held_nostrobe", 32'(start_rd_o), 32'd0);
        tick();
        end_rd_i = 1'b0;
        #1;
        chk("t2.issue_held", 32'(start_rd_o), 32'd0);
        chk("t2.issue_busy", 32'(busy_o), 32'd1);
        end_rd_i = 1'b1;
        tick();
        end_rd_i = 1'b0;
        #1;
        chk("t2.endrd_in_issue_ignored", 32'(start_rd_o), 32'd0);
        chk("t2.part_unchanged", 32'(part_idx_o), 32'd0);
        hold_i = 1'b0;
        issue_chk("t2b", 21, 0, 1, 0);
        // start_i and hold_i in WAIT without end_rd_i: no effect
        start_i = 1'b1;
        hold_i  = 1'b1;
        #1;
        chk("t2.start_in_wait", 32'(start_rd_o), 32'd0);
        tick();
        start_i = 1'b0;
        hold_i  = 1'b0;
        #1;
        chk("t2.wait_part", 32'(part_idx_o), 32'd1);
        chk("t2.wait_done", 32'(done_o), 32'd0);
        chk("t2.wait_nostrobe", 32'(start_rd_o), 32'd0);
        finish_chk("t2");

        // end_rd_i in IDLE: no effect
        end_rd_i = 1'b1;
        #1;
        chk("idle.endrd_nostrobe", 32'(start_rd_o), 32'd0);
        tick();
        end_rd_i = 1'b0;
        #1;
        chk("idle.endrd_busy", 32'(busy_o), 32'd0);

        // all 4x4, reset after the third strobe
        start_mb(2'd3, 8'hFF);
        issue_chk("t4.0", 9, 0, 0, 0);
        end_rd_i = 1'b1;
        issue_chk("t4.1", 9, 0, 0, 1);
        end_rd_i = 1'b1;
        issue_chk("t4.2", 9, 0, 0, 2);
        rst_i = 1'b1;
        tick();
        rst_i    = 1'b0;
        end_rd_i = 1'b1;
        #1;
        reset_chk("rst1");
        tick();
        end_rd_i = 1'b0;
        #1;
        chk("rst1.no_strobe", 32'(start_rd_o), 32'd0);
        chk("rst1.idle", 32'(busy_o), 32'd0);

        start_mb(2'd0, 8'd0);
        issue_chk("t5", 21, 1, 0, 0);
        tick();
        finish_chk("t5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
